// File: rtl/pong_pkg.sv
// Shared types and constants for the ball bounce sequencing logic.
package pong_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PLAY   = 2'd1,
      LOCKED = 2'd2
   } bounce_state_t;

   typedef logic signed [3:0] vvel_t;

   localparam logic [1:0] SPEED_SLOW  = 2'd0;
   localparam logic [1:0] SPEED_MID   = 2'd1;
   localparam logic [1:0] SPEED_FAST  = 2'd2;
   localparam logic [3:0] HIT_CNT_MAX = 4'd15;

   // Top of the paddle deflects upward; the two centre rows return the ball flat.
   function automatic vvel_t seg_to_vvel(input logic [2:0] seg);
      vvel_t v;
      case (seg)
         3'd0:    v = -4'sd3;
         3'd1:    v = -4'sd2;
         3'd2:    v = -4'sd1;
         3'd5:    v =  4'sd1;
         3'd6:    v =  4'sd2;
         3'd7:    v =  4'sd3;
         default: v =  4'sd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/seg_to_vvel_lut.sv
// Paddle segment (upper three bits of the row index) to vertical velocity.
module seg_to_vvel_lut
   import pong_pkg::*;
(
   input  logic [2:0] seg,
   output vvel_t      vvel
);

   assign vvel = seg_to_vvel(seg);

endmodule

// File: rtl/ball_bounce_ctrl.sv
// Paddle-contact sequencer: one bounce per contact, then owns direction,
// vertical velocity, rally speed level and the hit-sound gate.
//
// state  | meaning
// IDLE   | waiting for serve; hits ignored
// PLAY   | ball in flight; direction-consistent hit accepted
// LOCKED | bounce taken; wait for a frame with no hit strobes
module ball_bounce_ctrl
   import pong_pkg::*;
#(
   parameter int SND_FRAMES  = 4,
   parameter int SPEED1_HITS = 4,
   parameter int SPEED2_HITS = 12
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       HIT1_N,
   input  logic       HIT2_N,
   input  logic [3:0] PAD1_SEG,
   input  logic [3:0] PAD2_SEG,
   input  logic       VRESET,
   input  logic       SERVE,
   input  logic       SERVE_DIR,
   input  logic       MISS,
   output logic       DIR_R,
   output logic [3:0] VVEL,
   output logic [1:0] HSPEED,
   output logic [3:0] HIT_CNT,
   output logic       HIT_SND,
   output logic       IN_PLAY
);

   bounce_state_t state, state_nxt;
   vvel_t         vvel_q, vvel_nxt, lut_vvel;
   logic          dir_nxt, seen, seen_nxt, seen_frame;
   logic [1:0]    hspeed_nxt, speed_new;
   logic [3:0]    cnt_nxt, cnt_inc, snd_cnt, snd_nxt;
   logic [2:0]    lut_seg;
   logic          hit1, hit2, accept;
   logic          unused_seg_lsb;

   assign hit1   = ~HIT1_N;
   assign hit2   = ~HIT2_N;
   assign accept = (state == PLAY) && !MISS && ((hit1 && !DIR_R) || (hit2 && DIR_R));

   // Only the paddle the ball is heading toward can be accepted, so DIR_R picks it.
   assign lut_seg        = DIR_R ? PAD2_SEG[3:1] : PAD1_SEG[3:1];
   assign unused_seg_lsb = &{1'b0, PAD1_SEG[0], PAD2_SEG[0]};

   seg_to_vvel_lut u_lut (
      .seg  (lut_seg),
      .vvel (lut_vvel)
   );

   assign cnt_inc    = (HIT_CNT == HIT_CNT_MAX) ? HIT_CNT_MAX : HIT_CNT + 4'd1;
   assign speed_new  = (cnt_inc >= 4'(SPEED2_HITS)) ? SPEED_FAST :
                       (cnt_inc >= 4'(SPEED1_HITS)) ? SPEED_MID  : SPEED_SLOW;
   assign seen_frame = seen | hit1 | hit2;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= IDLE;
         DIR_R   <= 1'b0;
         vvel_q  <= '0;
         HSPEED  <= SPEED_SLOW;
         HIT_CNT <= '0;
         seen    <= 1'b0;
         snd_cnt <= '0;
      end else begin
         state   <= state_nxt;
         DIR_R   <= dir_nxt;
         vvel_q  <= vvel_nxt;
         HSPEED  <= hspeed_nxt;
         HIT_CNT <= cnt_nxt;
         seen    <= seen_nxt;
         snd_cnt <= snd_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      dir_nxt    = DIR_R;
      vvel_nxt   = vvel_q;
      hspeed_nxt = HSPEED;
      cnt_nxt    = HIT_CNT;
      seen_nxt   = 1'b0;
      snd_nxt    = (VRESET && snd_cnt != '0) ? snd_cnt - 4'd1 : snd_cnt;
      if (MISS) begin
         state_nxt = IDLE;
         snd_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (SERVE) begin
                  state_nxt  = PLAY;
                  dir_nxt    = SERVE_DIR;
                  vvel_nxt   = '0;
                  cnt_nxt    = '0;
                  hspeed_nxt = SPEED_SLOW;
               end
            end
            PLAY: begin
               if (accept) begin
                  state_nxt  = LOCKED;
                  dir_nxt    = ~DIR_R;
                  vvel_nxt   = lut_vvel;
                  cnt_nxt    = cnt_inc;
                  hspeed_nxt = speed_new;
                  snd_nxt    = 4'(SND_FRAMES);
                  seen_nxt   = 1'b1;
               end
            end
            LOCKED: begin
               // A strobe on the VRESET cycle itself still counts against the closing frame.
               if (VRESET) begin
                  if (!seen_frame) state_nxt = PLAY;
               end else begin
                  seen_nxt = seen_frame;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      IN_PLAY = (state != IDLE);
      HIT_SND = (snd_cnt != '0);
      VVEL    = vvel_q;
   end

endmodule

// File: tb/tb_ball_bounce_ctrl.sv
// Self-checking bench for ball_bounce_ctrl: directed scenarios plus a random run
// compared cycle by cycle against a rule-level reference model.
module tb_ball_bounce_ctrl;

   localparam int SND = 4;
   localparam int S1  = 4;
   localparam int S2  = 12;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       HIT1_N = 1'b1, HIT2_N = 1'b1;
   logic [3:0] PAD1_SEG = '0, PAD2_SEG = '0;
   logic       VRESET = 1'b0, SERVE = 1'b0, SERVE_DIR = 1'b0, MISS = 1'b0;
   logic       DIR_R, HIT_SND, IN_PLAY;
   logic [3:0] VVEL, HIT_CNT;
   logic [1:0] HSPEED;

   int checks = 0;
   int errors = 0;

   int vtab[8] = '{-3, -2, -1, 0, 0, 1, 2, 3};

   // model: 0 = idle, 1 = play, 2 = locked
   int m_state, m_vvel, m_cnt, m_spd, m_snd;
   bit m_dir, m_seen;

   always #5 CLK = ~CLK;

   ball_bounce_ctrl #(
      .SND_FRAMES  (SND),
      .SPEED1_HITS (S1),
      .SPEED2_HITS (S2)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .HIT1_N    (HIT1_N),
      .HIT2_N    (HIT2_N),
      .PAD1_SEG  (PAD1_SEG),
      .PAD2_SEG  (PAD2_SEG),
      .VRESET    (VRESET),
      .SERVE     (SERVE),
      .SERVE_DIR (SERVE_DIR),
      .MISS      (MISS),
      .DIR_R     (DIR_R),
      .VVEL      (VVEL),
      .HSPEED    (HSPEED),
      .HIT_CNT   (HIT_CNT),
      .HIT_SND   (HIT_SND),
      .IN_PLAY   (IN_PLAY)
   );

   function automatic void model_reset();
      m_state = 0; m_vvel = 0; m_cnt = 0; m_spd = 0; m_snd = 0;
      m_dir = 0; m_seen = 0;
   endfunction

   function automatic void model_step();
      bit h1, h2, acc;
      int seg;
      h1 = !HIT1_N;
      h2 = !HIT2_N;
      acc = 0;
      if (MISS) begin
         m_state = 0; m_snd = 0; m_seen = 0;
         return;
      end
      if (m_state == 0) begin
         if (SERVE) begin
            m_state = 1; m_dir = SERVE_DIR; m_vvel = 0; m_cnt = 0; m_spd = 0;
         end
      end else if (m_state == 1) begin
         if ((h1 && !m_dir) || (h2 && m_dir)) begin
            seg     = m_dir ? int'(PAD2_SEG) : int'(PAD1_SEG);
            m_dir   = !m_dir;
            m_vvel  = vtab[seg / 2];
            m_cnt   = (m_cnt < 15) ? m_cnt + 1 : 15;
            m_spd   = (m_cnt >= S2) ? 2 : (m_cnt >= S1) ? 1 : 0;
            m_snd   = SND;
            m_state = 2;
            m_seen  = 1;
            acc     = 1;
         end
      end else begin
         if (VRESET) begin
            if (!(m_seen || h1 || h2)) m_state = 1;
            m_seen = 0;
         end else begin
            m_seen = m_seen || h1 || h2;
         end
      end
      if (!acc && VRESET && m_snd > 0) m_snd = m_snd - 1;
   endfunction

   task automatic cyc();
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic vr();
      VRESET = 1'b1;
      cyc();
      VRESET = 1'b0;
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      model_reset();
      #23;
      checks++;
      if ({DIR_R, VVEL, HSPEED, HIT_CNT, HIT_SND, IN_PLAY} !== 13'd0) begin
         errors++;
         $display("FAIL reset_values: got %h expected 0", {DIR_R, VVEL, HSPEED, HIT_CNT, HIT_SND, IN_PLAY});
      end
      @(negedge CLK);
      RST_N = 1'b1;
      cyc();
      checks++;
      if ({DIR_R, VVEL, HSPEED, HIT_CNT, HIT_SND, IN_PLAY} !== 13'd0) begin
         errors++;
         $display("FAIL reset_release: got %h expected 0", {DIR_R, VVEL, HSPEED, HIT_CNT, HIT_SND, IN_PLAY});
      end
   endtask

   task automatic test_serve();
      HIT1_N = 1'b0; HIT2_N = 1'b0;
      cyc();
      HIT1_N = 1'b1; HIT2_N = 1'b1;
      checks++;
      if ({IN_PLAY, HIT_CNT} !== 5'd0) begin
         errors++;
         $display("FAIL idle_hit_ignored: got in_play=%0b cnt=%0d expected 0/0", IN_PLAY, HIT_CNT);
      end
      SERVE = 1'b1; SERVE_DIR = 1'b1;
      cyc();
      SERVE = 1'b0;
      checks++;
      if (IN_PLAY !== 1'b1) begin errors++; $display("FAIL serve_in_play: got %0b expected 1", IN_PLAY); end
      checks++;
      if (DIR_R !== 1'b1) begin errors++; $display("FAIL serve_dir: got %0b expected 1", DIR_R); end
      checks++;
      if ({VVEL, HIT_CNT, HSPEED} !== 10'd0) begin
         errors++;
         $display("FAIL serve_clear: got vvel=%0d cnt=%0d spd=%0d expected 0", VVEL, HIT_CNT, HSPEED);
      end
   endtask

   task automatic test_single_bounce();
      HIT1_N = 1'b0;
      cyc();
      HIT1_N = 1'b1;
      checks++;
      if ({DIR_R, HIT_CNT} !== 5'b1_0000) begin
         errors++;
         $display("FAIL away_hit_ignored: got dir=%0b cnt=%0d expected 1/0", DIR_R, HIT_CNT);
      end
      vr();
      PAD2_SEG = 4'd14;
      for (int i = 0; i < 6; i++) begin
         HIT2_N = 1'b0;
         cyc();
         HIT2_N = 1'b1;
         idle(3);
         if (i == 0) begin
            checks++;
            if (DIR_R !== 1'b0) begin errors++; $display("FAIL bounce_dir: got %0b expected 0", DIR_R); end
            checks++;
            if (VVEL !== 4'd3) begin errors++; $display("FAIL bounce_vvel: got %0d expected 3", $signed(VVEL)); end
            checks++;
            if (HIT_SND !== 1'b1) begin errors++; $display("FAIL bounce_snd: got %0b expected 1", HIT_SND); end
         end
      end
      checks++;
      if (HIT_CNT !== 4'd1) begin errors++; $display("FAIL one_bounce: got %0d expected 1", HIT_CNT); end
      // frame 1: consistent-paddle strobes while locked must not bounce
      vr();
      PAD1_SEG = 4'd0;
      repeat (2) begin
         HIT1_N = 1'b0;
         cyc();
         HIT1_N = 1'b1;
         idle(2);
      end
      checks++;
      if (HIT_CNT !== 4'd1) begin errors++; $display("FAIL locked_ignore: got %0d expected 1", HIT_CNT); end
      vr();
      idle(5);
      // strobe coincident with VRESET keeps the lock
      HIT1_N = 1'b0;
      vr();
      HIT1_N = 1'b1;
      checks++;
      if (HIT_CNT !== 4'd1) begin errors++; $display("FAIL coincident_ignore: got %0d expected 1", HIT_CNT); end
      checks++;
      if (HIT_SND !== 1'b1) begin errors++; $display("FAIL snd_frame3: got %0b expected 1", HIT_SND); end
      idle(3);
      HIT1_N = 1'b0;
      cyc();
      HIT1_N = 1'b1;
      idle(2);
      checks++;
      if (HIT_CNT !== 4'd1) begin errors++; $display("FAIL coincident_lock: got %0d expected 1", HIT_CNT); end
      vr();
      checks++;
      if (HIT_SND !== 1'b0) begin errors++; $display("FAIL snd_frame4: got %0b expected 0", HIT_SND); end
      idle(5);
      vr();
      HIT1_N = 1'b0;
      cyc();
      HIT1_N = 1'b1;
      checks++;
      if ({DIR_R, VVEL, HIT_CNT} !== {1'b1, 4'(-3), 4'd2}) begin
         errors++;
         $display("FAIL second_bounce: got dir=%0b vvel=%0d cnt=%0d expected 1/-3/2", DIR_R, $signed(VVEL), HIT_CNT);
      end
   endtask

   task automatic test_speed_saturate();
      int exp_cnt, exp_spd, seg;
      bit exp_dir;
      exp_cnt = 2;
      exp_dir = 1'b1;
      for (int i = 0; i < 15; i++) begin
         vr();
         vr();
         seg = int'($urandom_range(0, 15));
         if (exp_dir) begin PAD2_SEG = 4'(seg); HIT2_N = 1'b0; end
         else         begin PAD1_SEG = 4'(seg); HIT1_N = 1'b0; end
         cyc();
         HIT1_N = 1'b1; HIT2_N = 1'b1;
         exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
         exp_spd = (exp_cnt >= S2) ? 2 : (exp_cnt >= S1) ? 1 : 0;
         exp_dir = !exp_dir;
         checks++;
         if (HIT_CNT !== 4'(exp_cnt)) begin errors++; $display("FAIL speed_cnt[%0d]: got %0d expected %0d", i, HIT_CNT, exp_cnt); end
         checks++;
         if (HSPEED !== 2'(exp_spd)) begin errors++; $display("FAIL speed_lvl[%0d]: got %0d expected %0d", i, HSPEED, exp_spd); end
         checks++;
         if (DIR_R !== exp_dir) begin errors++; $display("FAIL speed_dir[%0d]: got %0b expected %0b", i, DIR_R, exp_dir); end
         checks++;
         if (VVEL !== 4'(vtab[seg / 2])) begin
            errors++;
            $display("FAIL speed_vvel[%0d]: got %0d expected %0d (seg %0d)", i, $signed(VVEL), vtab[seg / 2], seg);
         end
      end
   endtask

   task automatic test_miss();
      vr();
      vr();
      MISS = 1'b1; SERVE = 1'b1; SERVE_DIR = 1'b1; HIT1_N = 1'b0;
      cyc();
      MISS = 1'b0; SERVE = 1'b0; HIT1_N = 1'b1;
      checks++;
      if ({IN_PLAY, HIT_SND} !== 2'b00) begin
         errors++;
         $display("FAIL miss_idle: got in_play=%0b snd=%0b expected 0/0", IN_PLAY, HIT_SND);
      end
      checks++;
      if ({HIT_CNT, HSPEED, DIR_R} !== {4'd15, 2'd2, 1'b0}) begin
         errors++;
         $display("FAIL miss_hold: got cnt=%0d spd=%0d dir=%0b expected 15/2/0", HIT_CNT, HSPEED, DIR_R);
      end
      HIT1_N = 1'b0;
      cyc();
      HIT1_N = 1'b1;
      checks++;
      if ({IN_PLAY, HIT_CNT} !== {1'b0, 4'd15}) begin
         errors++;
         $display("FAIL miss_idle_hit: got in_play=%0b cnt=%0d expected 0/15", IN_PLAY, HIT_CNT);
      end
      SERVE = 1'b1; SERVE_DIR = 1'b0;
      cyc();
      SERVE = 1'b0;
      checks++;
      if ({IN_PLAY, DIR_R, HIT_CNT, HSPEED} !== {1'b1, 1'b0, 4'd0, 2'd0}) begin
         errors++;
         $display("FAIL reserve: got in_play=%0b dir=%0b cnt=%0d spd=%0d expected 1/0/0/0", IN_PLAY, DIR_R, HIT_CNT, HSPEED);
      end
   endtask

   task automatic test_async_reset();
      PAD1_SEG = 4'd5;
      HIT1_N = 1'b0;
      cyc();
      HIT1_N = 1'b1;
      checks++;
      if (HIT_SND !== 1'b1) begin errors++; $display("FAIL pre_reset_snd: got %0b expected 1", HIT_SND); end
      #2;
      RST_N = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({DIR_R, VVEL, HSPEED, HIT_CNT, HIT_SND, IN_PLAY} !== 13'd0) begin
         errors++;
         $display("FAIL async_reset: got %h expected 0", {DIR_R, VVEL, HSPEED, HIT_CNT, HIT_SND, IN_PLAY});
      end
      @(negedge CLK);
      RST_N = 1'b1;
      HIT1_N = 1'b0; HIT2_N = 1'b0;
      idle(3);
      HIT1_N = 1'b1; HIT2_N = 1'b1;
      checks++;
      if ({IN_PLAY, HIT_CNT, DIR_R} !== 6'd0) begin
         errors++;
         $display("FAIL post_reset_ignore: got in_play=%0b cnt=%0d dir=%0b expected 0", IN_PLAY, HIT_CNT, DIR_R);
      end
      SERVE = 1'b1; SERVE_DIR = 1'b1;
      cyc();
      SERVE = 1'b0;
      checks++;
      if ({IN_PLAY, DIR_R} !== 2'b11) begin
         errors++;
         $display("FAIL post_reset_serve: got in_play=%0b dir=%0b expected 1/1", IN_PLAY, DIR_R);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         HIT1_N    = ($urandom_range(0, 31) != 0);
         HIT2_N    = ($urandom_range(0, 31) != 0);
         PAD1_SEG  = 4'($urandom_range(0, 15));
         PAD2_SEG  = 4'($urandom_range(0, 15));
         VRESET    = ($urandom_range(0, 15) == 0);
         SERVE     = ($urandom_range(0, 39) == 0);
         SERVE_DIR = 1'($urandom_range(0, 1));
         MISS      = ($urandom_range(0, 199) == 0);
         cyc();
         checks++;
         if (IN_PLAY !== (m_state != 0)) begin errors++; $display("FAIL rnd_in_play @%0d: got %0b expected %0b", i, IN_PLAY, m_state != 0); end
         checks++;
         if (DIR_R !== m_dir) begin errors++; $display("FAIL rnd_dir @%0d: got %0b expected %0b", i, DIR_R, m_dir); end
         checks++;
         if (VVEL !== 4'(m_vvel)) begin errors++; $display("FAIL rnd_vvel @%0d: got %0d expected %0d", i, $signed(VVEL), m_vvel); end
         checks++;
         if (HIT_CNT !== 4'(m_cnt)) begin errors++; $display("FAIL rnd_cnt @%0d: got %0d expected %0d", i, HIT_CNT, m_cnt); end
         checks++;
         if (HSPEED !== 2'(m_spd)) begin errors++; $display("FAIL rnd_speed @%0d: got %0d expected %0d", i, HSPEED, m_spd); end
         checks++;
         if (HIT_SND !== (m_snd != 0)) begin errors++; $display("FAIL rnd_snd @%0d: got %0b expected %0b", i, HIT_SND, m_snd != 0); end
      end
      HIT1_N = 1'b1; HIT2_N = 1'b1; VRESET = 1'b0; SERVE = 1'b0; MISS = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      test_reset();
      test_serve();
      test_single_bounce();
      test_speed_saturate();
      test_miss();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ball_bounce_ctrl.md
# ball_bounce_ctrl

Sequences the ball's response to paddle contact. Consumes the per-paddle active-low hit strobes from hit detection and a paddle-segment index, then owns ball horizontal direction, vertical velocity, rally speed level and the hit-sound gate. It accepts exactly one bounce per paddle contact using a frame-based lock, so the repeated per-line hit strobes of one contact produce one bounce. It sits between hit detection and the ball motion counters, in the single video clock domain.

## Interface

Parameters:
- SND_FRAMES, 4: frames HIT_SND stays high after an accepted hit (1..15).
- SPEED1_HITS, 4: hit count at which HSPEED becomes 1.
- SPEED2_HITS, 12: hit count at which HSPEED becomes 2 (> SPEED1_HITS, ≤ 15).

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  video clock; all state on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- HIT1_N  in  1  left-paddle hit, active low, synchronous to CLK.
- HIT2_N  in  1  right-paddle hit, active low, synchronous to CLK.
- PAD1_SEG  in  4  ball row within left paddle, 0 = top, 15 = bottom.
- PAD2_SEG  in  4  ball row within right paddle.
- VRESET  in  1  one-CLK pulse at frame start.
- SERVE  in  1  one-CLK serve request.
- SERVE_DIR  in  1  serve direction, 1 = rightward.
- MISS  in  1  one-CLK pulse when the ball leaves the court.
- DIR_R  out  1  ball moving right.
- VVEL  out  4  signed vertical velocity, −3..+3, positive = down.
- HSPEED  out  2  horizontal speed level, 0..2.
- HIT_CNT  out  4  accepted hits this rally, saturates at 15.
- HIT_SND  out  1  hit-sound gate.
- IN_PLAY  out  1  high in PLAY or LOCKED.

## Operation

- States: IDLE, PLAY, LOCKED.
- IDLE: SERVE=1 and MISS=0 → PLAY. On that edge: DIR_R←SERVE_DIR, VVEL←0, HIT_CNT←0, HSPEED←0. Hits are ignored in IDLE.
- PLAY, accepted hit (→ LOCKED):
  - HIT1_N=0 with DIR_R=0, or HIT2_N=0 with DIR_R=1, is accepted.
  - A hit from the paddle the ball is moving away from is ignored.
  - Both low in the same cycle: only the direction-consistent paddle is accepted.
- On an accepted hit:
  - DIR_R toggles.
  - VVEL is set from the hitting paddle's SEG[3:1]: 0→−3, 1→−2, 2→−1, 3→0, 4→0, 5→+1, 6→+2, 7→+3.
  - HIT_CNT increments, saturating at 15.
  - HSPEED is recomputed from the new count: ≥SPEED2_HITS→2, ≥SPEED1_HITS→1, else 0.
  - The sound counter loads SND_FRAMES.
- LOCKED:
  - Hits are ignored, but any HIT1_N=0 or HIT2_N=0 sets the seen flag.
  - On VRESET: seen=0 → PLAY; seen=1 → stay LOCKED. Seen is cleared on every VRESET.
  - The frame containing the accepted hit therefore always counts as seen.
- MISS in any state → IDLE, HIT_SND←0, sound counter←0. DIR_R, VVEL, HSPEED and HIT_CNT hold. MISS wins over SERVE and over a hit in the same cycle.
- SERVE outside IDLE is ignored.
- Sound counter: decrements on each VRESET while nonzero. HIT_SND = (counter ≠ 0).
- IN_PLAY = (state ≠ IDLE).

## Timing

- All outputs are registered. A hit or SERVE sampled at edge n is visible on outputs after edge n (zero added cycles).
- Reset values: state IDLE, DIR_R 0, VVEL 0, HSPEED 0, HIT_CNT 0, HIT_SND 0, IN_PLAY 0, seen 0, sound counter 0.
- RST_N asserted mid-rally clears everything immediately and asynchronously. Release is synchronous; the first active edge after release behaves as IDLE.
- A hit coincident with VRESET in LOCKED sets seen before the VRESET evaluation, so the block stays LOCKED.
- A hit coincident with VRESET while the sound counter is nonzero reloads the counter to SND_FRAMES; it does not decrement.
- HIT_SND stays high for exactly SND_FRAMES VRESET pulses after acceptance.

## Structure

- pong_pkg holds:
  - the state enum (bounce_state_t: IDLE, PLAY, LOCKED);
  - the vvel_t signed 4-bit typedef;
  - the segment-to-velocity function seg_to_vvel;
  - speed-level constants.
- Sub-module seg_to_vvel_lut (combinational, 3-bit in → vvel_t out) is instantiated once, fed by a mux on the accepting paddle's SEG.
- Everything else is a single always_ff plus next-state logic.

## Test plan

- Reset, SERVE with SERVE_DIR=1 → IN_PLAY=1, DIR_R=1, VVEL=0, HIT_CNT=0, HSPEED=0.
- DIR_R=1, HIT2_N low for 6 scan lines with PAD2_SEG=14 → exactly one bounce: DIR_R=0, VVEL=+3, HIT_CNT=1, HIT_SND high for 4 frames. HIT1_N low while DIR_R=1 → ignored.
- Hit pulses continue into the next frame → stays LOCKED. One hit-free frame then HIT1_N low with PAD1_SEG=0 → DIR_R=1, VVEL=−3, HIT_CNT=2.
- 12 alternating accepted hits → HSPEED goes 0→1 at count 4 and 1→2 at count 12. Further hits saturate HIT_CNT at 15.
- MISS with a hit and SERVE in the same cycle → IDLE, HIT_SND=0, HIT_CNT unchanged. A later SERVE clears the count.
- RST_N pulsed low mid-LOCKED with HIT_SND=1 → all outputs 0 immediately. After release, hits are ignored until SERVE.
